// File: rtl/sdram_resp.sv
// sdram_resp: memory-side model of an SDRAM device for controller simulation
// and FPGA loopback builds without external SDRAM.
//
// Decodes the SDRAM command bus, tracks the mode register, per-bank open rows
// and the AREF count, stores write bursts in an internal array and returns
// read bursts after the programmed CAS latency. Protocol violations pulse
// err_proto for one cycle.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   sdram_cke/csn/rasn/casn/wen/ba/addr   command bus from the controller
//   sdram_data_i/_oe      write data and its drive enable
//   sdram_data_o/_valid   registered read data and beat valid
//   init_done             MRS accepted after at least two AREF (sticky)
//   mode_bl, mode_cl      decoded burst length (1/2/4/8) and CAS latency (2/3)
//   err_proto             one-cycle pulse on a protocol violation
//   err_timing            one-cycle pulse on a tRCD violation
//
// Optional feature macro: SDRAM_RESP_TRCD_CHK_EN enables per-bank tRCD
// counters driving err_timing; otherwise err_timing is tied low.
module sdram_resp #(
  parameter int ROW_AW = 4,
  parameter int COL_AW = 5,
  parameter int TRCD   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdram_cke,
  input  logic        sdram_csn,
  input  logic        sdram_rasn,
  input  logic        sdram_casn,
  input  logic        sdram_wen,
  input  logic [1:0]  sdram_ba,
  input  logic [12:0] sdram_addr,
  input  logic [15:0] sdram_data_i,
  input  logic        sdram_data_oe,
  output logic [15:0] sdram_data_o,
  output logic        sdram_data_o_valid,
  output logic        init_done,
  output logic [3:0]  mode_bl,
  output logic [1:0]  mode_cl,
  output logic        err_proto,
  output logic        err_timing
);

  localparam int AW    = 2 + ROW_AW + COL_AW;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    CMD_MRS   = 3'b000,
    CMD_AREF  = 3'b001,
    CMD_PRE   = 3'b010,
    CMD_ACT   = 3'b011,
    CMD_WRITE = 3'b100,
    CMD_READ  = 3'b101,
    CMD_BST   = 3'b110,
    CMD_NOP   = 3'b111
  } cmd_e;

  logic [15:0] mem [DEPTH];

  logic [3:0]             bank_open_q, bank_open_d;
  logic [3:0][ROW_AW-1:0] bank_row_q,  bank_row_d;
  logic [1:0]             aref_cnt_q,  aref_cnt_d;
  logic                   init_done_q, init_done_d;
  logic [3:0]             mode_bl_q,   mode_bl_d;
  logic [1:0]             mode_cl_q,   mode_cl_d;
  // active burst (beats 1..BL-1 still to issue)
  logic                   bst_act_q,  bst_act_d;
  logic                   bst_wr_q,   bst_wr_d;
  logic [1:0]             bst_ba_q,   bst_ba_d;
  logic [ROW_AW-1:0]      bst_row_q,  bst_row_d;
  logic [COL_AW-1:0]      bst_col_q,  bst_col_d;
  logic [2:0]             bst_beat_q, bst_beat_d;
  logic [2:0]             bst_last_q, bst_last_d;
  logic                   bst_ap_q,   bst_ap_d;
  logic                   ap_pend_q,  ap_pend_d;
  logic [1:0]             ap_ba_q,    ap_ba_d;
  // read return pipeline; stage 0 holds the array read of the issue cycle
  logic [2:0]             vld_pipe_q, vld_pipe_d;
  logic [2:0][15:0]       dat_pipe_q, dat_pipe_d;
  logic                   dout_vld_q, dout_vld_d;
  logic [15:0]            dout_q,     dout_d;
  logic                   err_proto_q, err_proto_d;

  logic                   iss, iss_wr;
  logic [1:0]             iss_ba;
  logic [ROW_AW-1:0]      iss_row;
  logic [COL_AW-1:0]      iss_base, iss_col, col_mask;
  logic [2:0]             iss_beat, iss_last;
  logic [AW-1:0]          iss_addr;
  logic                   mem_we;
  logic [1:0]             cl_idx;
  logic [2:0]             bl_m1;

  cmd_e cmd;
  logic cmd_vld, rw_cmd, rw_ok;

  assign cmd_vld = sdram_cke & ~sdram_csn;
  assign cmd     = cmd_e'({sdram_rasn, sdram_casn, sdram_wen});
  assign rw_cmd  = cmd_vld && (cmd == CMD_READ || cmd == CMD_WRITE);
  assign rw_ok   = rw_cmd && init_done_q && bank_open_q[sdram_ba];
  assign bl_m1   = 3'(mode_bl_q - 4'd1);
  // output register taps stage CL-1 so the first beat appears CL edges after READ
  assign cl_idx  = (mode_cl_q == 2'd2) ? 2'd1 : 2'd2;

  logic unused_addr;
  assign unused_addr = ^sdram_addr;

  always_comb begin
    bank_open_d = bank_open_q;
    bank_row_d  = bank_row_q;
    aref_cnt_d  = aref_cnt_q;
    init_done_d = init_done_q;
    mode_bl_d   = mode_bl_q;
    mode_cl_d   = mode_cl_q;
    bst_act_d   = bst_act_q;
    bst_wr_d    = bst_wr_q;
    bst_ba_d    = bst_ba_q;
    bst_row_d   = bst_row_q;
    bst_col_d   = bst_col_q;
    bst_beat_d  = bst_beat_q;
    bst_last_d  = bst_last_q;
    bst_ap_d    = bst_ap_q;
    ap_pend_d   = ap_pend_q;
    ap_ba_d     = ap_ba_q;
    vld_pipe_d  = vld_pipe_q;
    dat_pipe_d  = dat_pipe_q;
    dout_vld_d  = dout_vld_q;
    dout_d      = dout_q;
    err_proto_d = 1'b0;
    iss         = 1'b0;
    iss_wr      = bst_wr_q;
    iss_ba      = bst_ba_q;
    iss_row     = bst_row_q;
    iss_base    = bst_col_q;
    iss_beat    = bst_beat_q;
    iss_last    = bst_last_q;

    if (sdram_cke) begin
      // auto-precharge lands one edge after the final beat was issued
      if (ap_pend_q) begin
        bank_open_d[ap_ba_q] = 1'b0;
        ap_pend_d            = 1'b0;
      end

      // burst sequencing: a new READ/WRITE truncates, BST stops issuing
      if (rw_ok) begin
        iss        = 1'b1;
        iss_wr     = (cmd == CMD_WRITE);
        iss_ba     = sdram_ba;
        iss_row    = bank_row_q[sdram_ba];
        iss_base   = sdram_addr[COL_AW-1:0];
        iss_beat   = 3'd0;
        iss_last   = bl_m1;
        bst_act_d  = (bl_m1 != 3'd0);
        bst_wr_d   = (cmd == CMD_WRITE);
        bst_ba_d   = sdram_ba;
        bst_row_d  = bank_row_q[sdram_ba];
        bst_col_d  = sdram_addr[COL_AW-1:0];
        bst_beat_d = 3'd1;
        bst_last_d = bl_m1;
        bst_ap_d   = sdram_addr[10];
        if (bl_m1 == 3'd0 && sdram_addr[10]) begin
          ap_pend_d = 1'b1;
          ap_ba_d   = sdram_ba;
        end
      end else if (cmd_vld && cmd == CMD_BST) begin
        bst_act_d = 1'b0;
      end else if (bst_act_q) begin
        iss        = 1'b1;
        bst_beat_d = bst_beat_q + 3'd1;
        if (bst_beat_q == bst_last_q) begin
          bst_act_d = 1'b0;
          if (bst_ap_q) begin
            ap_pend_d = 1'b1;
            ap_ba_d   = bst_ba_q;
          end
        end
      end

      if (cmd_vld) begin
        case (cmd)
          CMD_ACT: begin
            if (bank_open_q[sdram_ba]) err_proto_d = 1'b1;
            bank_open_d[sdram_ba] = 1'b1;
            bank_row_d[sdram_ba]  = sdram_addr[ROW_AW-1:0];
          end
          CMD_PRE: begin
            if (sdram_addr[10]) bank_open_d = '0;
            else                bank_open_d[sdram_ba] = 1'b0;
          end
          CMD_AREF: begin
            if (|bank_open_q) err_proto_d = 1'b1;
            if (aref_cnt_q != 2'd3) aref_cnt_d = aref_cnt_q + 2'd1;
          end
          CMD_MRS: begin
            case (sdram_addr[2:0])
              3'd0:    mode_bl_d = 4'd1;
              3'd1:    mode_bl_d = 4'd2;
              3'd2:    mode_bl_d = 4'd4;
              3'd3:    mode_bl_d = 4'd8;
              default: begin mode_bl_d = 4'd1; err_proto_d = 1'b1; end
            endcase
            case (sdram_addr[6:4])
              3'd2:    mode_cl_d = 2'd2;
              3'd3:    mode_cl_d = 2'd3;
              default: begin mode_cl_d = 2'd3; err_proto_d = 1'b1; end
            endcase
            if (aref_cnt_q[1]) init_done_d = 1'b1;
          end
          CMD_READ, CMD_WRITE: begin
            if (!rw_ok) err_proto_d = 1'b1;
          end
          default: ;
        endcase
      end
    end

    // sequential column within the BL-aligned block
    col_mask = COL_AW'(iss_last);
    iss_col  = (iss_base & ~col_mask) | ((iss_base + COL_AW'(iss_beat)) & col_mask);
    iss_addr = {iss_ba, iss_row, iss_col};
    mem_we   = iss & iss_wr & sdram_data_oe & ~rst;

    if (sdram_cke) begin
      vld_pipe_d = {vld_pipe_q[1:0], iss & ~iss_wr};
      dat_pipe_d = {dat_pipe_q[1:0], mem[iss_addr]};
      dout_vld_d = vld_pipe_q[cl_idx];
      dout_d     = dat_pipe_q[cl_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[iss_addr] <= sdram_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_open_q <= '0;
      bank_row_q  <= '0;
      aref_cnt_q  <= '0;
      init_done_q <= 1'b0;
      mode_bl_q   <= 4'd1;
      mode_cl_q   <= 2'd3;
      bst_act_q   <= 1'b0;
      bst_wr_q    <= 1'b0;
      bst_ba_q    <= '0;
      bst_row_q   <= '0;
      bst_col_q   <= '0;
      bst_beat_q  <= '0;
      bst_last_q  <= '0;
      bst_ap_q    <= 1'b0;
      ap_pend_q   <= 1'b0;
      ap_ba_q     <= '0;
      vld_pipe_q  <= '0;
      dat_pipe_q  <= '0;
      dout_vld_q  <= 1'b0;
      dout_q      <= '0;
      err_proto_q <= 1'b0;
    end else begin
      bank_open_q <= bank_open_d;
      bank_row_q  <= bank_row_d;
      aref_cnt_q  <= aref_cnt_d;
      init_done_q <= init_done_d;
      mode_bl_q   <= mode_bl_d;
      mode_cl_q   <= mode_cl_d;
      bst_act_q   <= bst_act_d;
      bst_wr_q    <= bst_wr_d;
      bst_ba_q    <= bst_ba_d;
      bst_row_q   <= bst_row_d;
      bst_col_q   <= bst_col_d;
      bst_beat_q  <= bst_beat_d;
      bst_last_q  <= bst_last_d;
      bst_ap_q    <= bst_ap_d;
      ap_pend_q   <= ap_pend_d;
      ap_ba_q     <= ap_ba_d;
      vld_pipe_q  <= vld_pipe_d;
      dat_pipe_q  <= dat_pipe_d;
      dout_vld_q  <= dout_vld_d;
      dout_q      <= dout_d;
      err_proto_q <= err_proto_d;
    end
  end

`ifdef SDRAM_RESP_TRCD_CHK_EN
  localparam int TW = (TRCD > 1) ? $clog2(TRCD) : 1;

  logic [3:0][TW-1:0] trcd_cnt_q, trcd_cnt_d;
  logic               err_timing_q, err_timing_d;

  // counters run every clock; the command itself still executes on a violation
  always_comb begin
    for (int b = 0; b < 4; b++)
      trcd_cnt_d[b] = (trcd_cnt_q[b] != '0) ? trcd_cnt_q[b] - TW'(1) : '0;
    if (cmd_vld && cmd == CMD_ACT) trcd_cnt_d[sdram_ba] = TW'(TRCD - 1);
    err_timing_d = rw_cmd && (trcd_cnt_q[sdram_ba] != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trcd_cnt_q   <= '0;
      err_timing_q <= 1'b0;
    end else begin
      trcd_cnt_q   <= trcd_cnt_d;
      err_timing_q <= err_timing_d;
    end
  end

  assign err_timing = err_timing_q;
`else
  logic unused_trcd;
  assign unused_trcd = (TRCD > 0);
  assign err_timing  = 1'b0;
`endif

  assign sdram_data_o       = dout_q;
  assign sdram_data_o_valid = dout_vld_q;
  assign init_done          = init_done_q;
  assign mode_bl            = mode_bl_q;
  assign mode_cl            = mode_cl_q;
  assign err_proto          = err_proto_q;

endmodule

// File: tb/tb_sdram_resp.sv
// Directed testbench for sdram_resp: each scenario task drives the command
// bus one edge at a time, logs valid/data after every edge, and compares
// against hand-computed expectations.
module tb_sdram_resp;

  localparam logic [2:0] C_MRS = 3'b000, C_AREF = 3'b001, C_PRE = 3'b010,
                         C_ACT = 3'b011, C_WR = 3'b100, C_RD = 3'b101,
                         C_BST = 3'b110, C_NOP = 3'b111;
`ifdef SDRAM_RESP_TRCD_CHK_EN
  localparam logic TCHK = 1'b1;
`else
  localparam logic TCHK = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        sdram_cke = 1'b1, sdram_csn = 1'b0;
  logic        sdram_rasn = 1'b1, sdram_casn = 1'b1, sdram_wen = 1'b1;
  logic [1:0]  sdram_ba = '0;
  logic [12:0] sdram_addr = '0;
  logic [15:0] sdram_data_i = '0;
  logic        sdram_data_oe = 1'b0;
  logic [15:0] sdram_data_o;
  logic        sdram_data_o_valid, init_done, err_proto, err_timing;
  logic [3:0]  mode_bl;
  logic [1:0]  mode_cl;

  int n_cmp = 0, n_bad = 0;
  logic        lg_vld[$];
  logic [15:0] lg_dat[$];

  sdram_resp #(.ROW_AW(4), .COL_AW(5), .TRCD(3)) dut (
    .clk(clk), .rst(rst), .sdram_cke(sdram_cke), .sdram_csn(sdram_csn),
    .sdram_rasn(sdram_rasn), .sdram_casn(sdram_casn), .sdram_wen(sdram_wen),
    .sdram_ba(sdram_ba), .sdram_addr(sdram_addr), .sdram_data_i(sdram_data_i),
    .sdram_data_oe(sdram_data_oe), .sdram_data_o(sdram_data_o),
    .sdram_data_o_valid(sdram_data_o_valid), .init_done(init_done),
    .mode_bl(mode_bl), .mode_cl(mode_cl), .err_proto(err_proto),
    .err_timing(err_timing)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // one edge: drive command, clock, sample #1 later, then return to NOP
  task automatic step(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                      input logic [15:0] d, input logic oe);
    {sdram_rasn, sdram_casn, sdram_wen} = c;
    sdram_ba = ba; sdram_addr = a; sdram_data_i = d; sdram_data_oe = oe;
    @(posedge clk); #1;
    lg_vld.push_back(sdram_data_o_valid);
    lg_dat.push_back(sdram_data_o);
    {sdram_rasn, sdram_casn, sdram_wen} = C_NOP;
    sdram_data_oe = 1'b0;
  endtask

  task automatic nop(input int n);
    repeat (n) step(C_NOP, 2'd0, 13'd0, 16'd0, 1'b0);
  endtask

  task automatic clr_log();
    lg_vld.delete(); lg_dat.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; nop(2);
    n_cmp++; if (sdram_data_o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", sdram_data_o_valid); end
    n_cmp++; if (sdram_data_o !== 16'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0000", sdram_data_o); end
    n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL reset_init: got %b want 0", init_done); end
    n_cmp++; if (mode_bl !== 4'd1) begin n_bad++; $display("FAIL reset_bl: got %0d want 1", mode_bl); end
    n_cmp++; if (mode_cl !== 2'd3) begin n_bad++; $display("FAIL reset_cl: got %0d want 3", mode_cl); end
    n_cmp++; if ({err_proto, err_timing} !== 2'b00) begin n_bad++; $display("FAIL reset_err: got %b want 00", {err_proto, err_timing}); end
    rst = 1'b0; nop(1);
  endtask

  task automatic test_init();
    step(C_MRS, 2'd0, 13'h032, 16'd0, 1'b0);
    n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL early_mrs_init: got %b want 0", init_done); end
    n_cmp++; if (err_proto !== 1'b0) begin n_bad++; $display("FAIL early_mrs_err: got %b want 0", err_proto); end
    step(C_AREF, 2'd0, 13'd0, 16'd0, 1'b0);
    step(C_AREF, 2'd0, 13'd0, 16'd0, 1'b0);
    n_cmp++; if (err_proto !== 1'b0) begin n_bad++; $display("FAIL aref_idle_err: got %b want 0", err_proto); end
    step(C_MRS, 2'd0, 13'h032, 16'd0, 1'b0);
    n_cmp++; if (init_done !== 1'b1) begin n_bad++; $display("FAIL init_done: got %b want 1", init_done); end
    n_cmp++; if (mode_bl !== 4'd4) begin n_bad++; $display("FAIL init_bl: got %0d want 4", mode_bl); end
    n_cmp++; if (mode_cl !== 2'd3) begin n_bad++; $display("FAIL init_cl: got %0d want 3", mode_cl); end
  endtask

  task automatic test_roundtrip();
    logic ev;
    step(C_ACT, 2'd1, 13'd3, 16'd0, 1'b0);
    step(C_WR,  2'd1, 13'd0, 16'hA000, 1'b1);
    step(C_NOP, 2'd0, 13'd0, 16'hA001, 1'b1);
    step(C_NOP, 2'd0, 13'd0, 16'hA002, 1'b1);
    step(C_NOP, 2'd0, 13'd0, 16'hA003, 1'b1);
    clr_log();
    step(C_RD, 2'd1, 13'd0, 16'd0, 1'b0);
    nop(8);
    for (int i = 0; i < 9; i++) begin
      ev = (i >= 3 && i <= 6);
      n_cmp++; if (lg_vld[i] !== ev) begin n_bad++; $display("FAIL rt_valid[%0d]: got %b want %b", i, lg_vld[i], ev); end
      if (ev) begin
        n_cmp++; if (lg_dat[i] !== 16'hA000 + 16'(i - 3)) begin n_bad++; $display("FAIL rt_data[%0d]: got %h want %h", i, lg_dat[i], 16'hA000 + 16'(i - 3)); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp [4];
    exp = '{16'h00B2, 16'h00B3, 16'h00B0, 16'h00B1};
    step(C_WR,  2'd1, 13'd0, 16'h00B0, 1'b1);
    step(C_NOP, 2'd0, 13'd0, 16'h00B1, 1'b1);
    step(C_NOP, 2'd0, 13'd0, 16'h00B2, 1'b1);
    step(C_NOP, 2'd0, 13'd0, 16'h00B3, 1'b1);
    clr_log();
    step(C_RD, 2'd1, 13'd2, 16'd0, 1'b0);
    nop(7);
    for (int i = 3; i <= 6; i++) begin
      n_cmp++; if (lg_vld[i] !== 1'b1 || lg_dat[i] !== exp[i-3]) begin n_bad++; $display("FAIL wrap[%0d]: got %b/%h want 1/%h", i, lg_vld[i], lg_dat[i], exp[i-3]); end
    end
    n_cmp++; if (lg_vld[7] !== 1'b0) begin n_bad++; $display("FAIL wrap_end: got %b want 0", lg_vld[7]); end
  endtask

  task automatic test_oe_skip();
    logic [15:0] exp [4];
    exp = '{16'h00E0, 16'h00D1, 16'h00E2, 16'h00D3};
    step(C_WR,  2'd1, 13'd4, 16'h00D0, 1'b1);
    step(C_NOP, 2'd0, 13'd0, 16'h00D1, 1'b1);
    step(C_NOP, 2'd0, 13'd0, 16'h00D2, 1'b1);
    step(C_NOP, 2'd0, 13'd0, 16'h00D3, 1'b1);
    step(C_WR,  2'd1, 13'd4, 16'h00E0, 1'b1);
    step(C_NOP, 2'd0, 13'd0, 16'h00E1, 1'b0);
    step(C_NOP, 2'd0, 13'd0, 16'h00E2, 1'b1);
    step(C_NOP, 2'd0, 13'd0, 16'h00E3, 1'b0);
    n_cmp++; if (err_proto !== 1'b0) begin n_bad++; $display("FAIL oe_skip_err: got %b want 0", err_proto); end
    clr_log();
    step(C_RD, 2'd1, 13'd4, 16'd0, 1'b0);
    nop(7);
    for (int i = 3; i <= 6; i++) begin
      n_cmp++; if (lg_vld[i] !== 1'b1 || lg_dat[i] !== exp[i-3]) begin n_bad++; $display("FAIL oe_skip[%0d]: got %b/%h want 1/%h", i, lg_vld[i], lg_dat[i], exp[i-3]); end
    end
  endtask

  task automatic test_errors();
    int nv;
    clr_log();
    step(C_RD, 2'd2, 13'd0, 16'd0, 1'b0);
    n_cmp++; if (err_proto !== 1'b1) begin n_bad++; $display("FAIL closed_read_err: got %b want 1", err_proto); end
    nop(6);
    n_cmp++; if (err_proto !== 1'b0) begin n_bad++; $display("FAIL closed_read_pulse: got %b want 0", err_proto); end
    nv = 0;
    foreach (lg_vld[i]) if (lg_vld[i] === 1'b1) nv++;
    n_cmp++; if (nv !== 0) begin n_bad++; $display("FAIL closed_read_valid: got %0d beats want 0", nv); end
    step(C_ACT, 2'd0, 13'd0, 16'd0, 1'b0);
    n_cmp++; if (err_proto !== 1'b0) begin n_bad++; $display("FAIL act_closed_err: got %b want 0", err_proto); end
    step(C_ACT, 2'd0, 13'd0, 16'd0, 1'b0);
    n_cmp++; if (err_proto !== 1'b1) begin n_bad++; $display("FAIL act_open_err: got %b want 1", err_proto); end
    step(C_AREF, 2'd0, 13'd0, 16'd0, 1'b0);
    n_cmp++; if (err_proto !== 1'b1) begin n_bad++; $display("FAIL aref_open_err: got %b want 1", err_proto); end
    nop(1);
    n_cmp++; if (err_proto !== 1'b0) begin n_bad++; $display("FAIL aref_open_pulse: got %b want 0", err_proto); end
    step(C_MRS, 2'd0, 13'h077, 16'd0, 1'b0);
    n_cmp++; if (err_proto !== 1'b1) begin n_bad++; $display("FAIL mrs_bad_err: got %b want 1", err_proto); end
    n_cmp++; if (mode_bl !== 4'd1 || mode_cl !== 2'd3) begin n_bad++; $display("FAIL mrs_bad_mode: got bl=%0d cl=%0d want bl=1 cl=3", mode_bl, mode_cl); end
    n_cmp++; if (init_done !== 1'b1) begin n_bad++; $display("FAIL init_sticky: got %b want 1", init_done); end
    step(C_PRE, 2'd0, 13'h400, 16'd0, 1'b0);
  endtask

  task automatic test_truncate();
    logic [15:0] exp [10];
    logic ev;
    exp = '{16'h00B0, 16'h00B1, 16'h00E0, 16'h00D1, 16'h00E2,
            16'h00D3, 16'h00B0, 16'h00B1, 16'h00B2, 16'h00B3};
    step(C_MRS, 2'd0, 13'h023, 16'd0, 1'b0);
    n_cmp++; if (mode_bl !== 4'd8 || mode_cl !== 2'd2) begin n_bad++; $display("FAIL mrs_bl8: got bl=%0d cl=%0d want bl=8 cl=2", mode_bl, mode_cl); end
    step(C_ACT, 2'd1, 13'd3, 16'd0, 1'b0);
    clr_log();
    step(C_RD, 2'd1, 13'd0, 16'd0, 1'b0);
    nop(1);
    step(C_RD, 2'd1, 13'd4, 16'd0, 1'b0);
    nop(12);
    for (int i = 0; i < 15; i++) begin
      ev = (i >= 2 && i <= 11);
      n_cmp++; if (lg_vld[i] !== ev) begin n_bad++; $display("FAIL trunc_valid[%0d]: got %b want %b", i, lg_vld[i], ev); end
      if (ev) begin
        n_cmp++; if (lg_dat[i] !== exp[i-2]) begin n_bad++; $display("FAIL trunc_data[%0d]: got %h want %h", i, lg_dat[i], exp[i-2]); end
      end
    end
  endtask

  task automatic test_suspend();
    logic [15:0] exp [15];
    logic ev;
    exp = '{16'h0, 16'h0, 16'h00B0, 16'h00B0, 16'h00B0, 16'h00B0, 16'h00B1, 16'h00B2,
            16'h00B3, 16'h00E0, 16'h00D1, 16'h00E2, 16'h00D3, 16'h0, 16'h0};
    clr_log();
    step(C_RD, 2'd1, 13'd0, 16'd0, 1'b0);
    nop(2);
    sdram_cke = 1'b0; nop(3);
    sdram_cke = 1'b1; nop(9);
    for (int i = 0; i < 15; i++) begin
      ev = (i >= 2 && i <= 12);
      n_cmp++; if (lg_vld[i] !== ev) begin n_bad++; $display("FAIL susp_valid[%0d]: got %b want %b", i, lg_vld[i], ev); end
      if (ev) begin
        n_cmp++; if (lg_dat[i] !== exp[i]) begin n_bad++; $display("FAIL susp_data[%0d]: got %h want %h", i, lg_dat[i], exp[i]); end
      end
    end
  endtask

  task automatic test_bst();
    logic ev;
    clr_log();
    step(C_RD, 2'd1, 13'd0, 16'd0, 1'b0);
    nop(1);
    step(C_BST, 2'd0, 13'd0, 16'd0, 1'b0);
    nop(8);
    for (int i = 0; i < 11; i++) begin
      ev = (i == 2 || i == 3);
      n_cmp++; if (lg_vld[i] !== ev) begin n_bad++; $display("FAIL bst_valid[%0d]: got %b want %b", i, lg_vld[i], ev); end
      if (ev) begin
        n_cmp++; if (lg_dat[i] !== 16'h00B0 + 16'(i - 2)) begin n_bad++; $display("FAIL bst_data[%0d]: got %h want %h", i, lg_dat[i], 16'h00B0 + 16'(i - 2)); end
      end
    end
  endtask

  task automatic test_autopre();
    int nv;
    clr_log();
    step(C_RD, 2'd1, 13'h400, 16'd0, 1'b0);
    nop(9);
    nv = 0;
    foreach (lg_vld[i]) if (lg_vld[i] === 1'b1) nv++;
    n_cmp++; if (nv !== 8) begin n_bad++; $display("FAIL ap_beats: got %0d want 8", nv); end
    step(C_RD, 2'd1, 13'd0, 16'd0, 1'b0);
    n_cmp++; if (err_proto !== 1'b1) begin n_bad++; $display("FAIL ap_bank_closed: got %b want 1", err_proto); end
    nop(1);
  endtask

  task automatic test_trcd();
    step(C_ACT, 2'd2, 13'd0, 16'd0, 1'b0);
    step(C_RD,  2'd2, 13'd0, 16'd0, 1'b0);
    n_cmp++; if (err_timing !== TCHK) begin n_bad++; $display("FAIL trcd_early: got %b want %b", err_timing, TCHK); end
    n_cmp++; if (err_proto !== 1'b0) begin n_bad++; $display("FAIL trcd_early_proto: got %b want 0", err_proto); end
    step(C_PRE, 2'd2, 13'd0, 16'd0, 1'b0);
    step(C_ACT, 2'd2, 13'd0, 16'd0, 1'b0);
    nop(2);
    step(C_RD,  2'd2, 13'd0, 16'd0, 1'b0);
    n_cmp++; if (err_timing !== 1'b0) begin n_bad++; $display("FAIL trcd_ok: got %b want 0", err_timing); end
    nop(10);
  endtask

  task automatic test_reset_mid_burst();
    int nv;
    logic ev;
    step(C_ACT, 2'd1, 13'd3, 16'd0, 1'b0);
    clr_log();
    step(C_RD, 2'd1, 13'd0, 16'd0, 1'b0);
    nop(2);
    n_cmp++; if (lg_vld[2] !== 1'b1 || lg_dat[2] !== 16'h00B0) begin n_bad++; $display("FAIL pre_rst_beat: got %b/%h want 1/00b0", lg_vld[2], lg_dat[2]); end
    rst = 1'b1; nop(1); rst = 1'b0;
    n_cmp++; if (sdram_data_o_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %b want 0", sdram_data_o_valid); end
    n_cmp++; if (init_done !== 1'b0 || mode_bl !== 4'd1 || mode_cl !== 2'd3) begin n_bad++; $display("FAIL rst_mid_state: got init=%b bl=%0d cl=%0d want 0/1/3", init_done, mode_bl, mode_cl); end
    clr_log();
    nop(6);
    nv = 0;
    foreach (lg_vld[i]) if (lg_vld[i] === 1'b1) nv++;
    n_cmp++; if (nv !== 0) begin n_bad++; $display("FAIL rst_mid_beats: got %0d want 0", nv); end
    // storage survives reset: re-init with BL2/CL2 and read it back
    step(C_AREF, 2'd0, 13'd0, 16'd0, 1'b0);
    step(C_AREF, 2'd0, 13'd0, 16'd0, 1'b0);
    step(C_MRS,  2'd0, 13'h021, 16'd0, 1'b0);
    step(C_ACT,  2'd1, 13'd3, 16'd0, 1'b0);
    clr_log();
    step(C_RD, 2'd1, 13'd0, 16'd0, 1'b0);
    nop(5);
    for (int i = 0; i < 6; i++) begin
      ev = (i == 2 || i == 3);
      n_cmp++; if (lg_vld[i] !== ev) begin n_bad++; $display("FAIL keep_valid[%0d]: got %b want %b", i, lg_vld[i], ev); end
      if (ev) begin
        n_cmp++; if (lg_dat[i] !== 16'h00B0 + 16'(i - 2)) begin n_bad++; $display("FAIL keep_data[%0d]: got %h want %h", i, lg_dat[i], 16'h00B0 + 16'(i - 2)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_roundtrip();
    test_wrap();
    test_oe_skip();
    test_errors();
    test_truncate();
    test_suspend();
    test_bst();
    test_autopre();
    test_trcd();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
